// File: rtl/pmips_pkg.sv
// Shared constants, slot record and match helper for the pmips hazard/forwarding logic.
// All register fields are held at SLOT_AW bits so one slot type serves every RAW <= SLOT_AW.
package pmips_pkg;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   localparam int SLOT_AW = 8;

   typedef logic [SLOT_AW-1:0] reg_addr_t;

   typedef struct packed {
      logic      valid;
      logic      wen;
      reg_addr_t dst;
      logic      load;
      reg_addr_t rs1;
      reg_addr_t rs2;
      logic      use1;
      logic      use2;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '0;

   // True when a producer slot writes the register a consumer actually reads.
   function automatic logic slot_match(
      input logic      valid,
      input logic      wen,
      input reg_addr_t dst,
      input reg_addr_t src,
      input logic      use_bit,
      input logic      r0_zero
   );
      return valid && wen && use_bit && (dst == src) && !(r0_zero && (src == '0));
   endfunction

endpackage

// File: rtl/pmips_fwd_mux.sv
// Three-way operand select for one ALU input: register file, EX/MEM result or WB data.
module pmips_fwd_mux
   import pmips_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [1:0]    sel,
   input  logic [DW-1:0] reg_data,
   input  logic [DW-1:0] mem_data,
   input  logic [DW-1:0] wb_data,
   output logic [DW-1:0] operand
);

   // The unused encoding falls back to the register-file value.
   always_comb begin
      operand = reg_data;
      case (sel)
         FWD_MEM: operand = mem_data;
         FWD_WB:  operand = wb_data;
         default: operand = reg_data;
      endcase
   end

endmodule

// File: rtl/pmips_hazard_unit.sv
// Load-use stall, branch flush and EX operand forwarding for the five-stage MIPS-lite core.
// Tracks the destination of each in-flight instruction in EX, MEM and WB slots.
module pmips_hazard_unit
   import pmips_pkg::*;
#(
   parameter int DW      = 16,
   parameter int RAW     = 3,
   parameter int CW      = 16,
   parameter int R0_ZERO = 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           id_valid,
   input  logic [RAW-1:0] id_rs1,
   input  logic [RAW-1:0] id_rs2,
   input  logic           id_use1,
   input  logic           id_use2,
   input  logic           id_wen,
   input  logic [RAW-1:0] id_wdst,
   input  logic           id_load,
   input  logic           ex_taken,
   input  logic [DW-1:0]  ex_rdata1,
   input  logic [DW-1:0]  ex_rdata2,
   input  logic [DW-1:0]  mem_result,
   input  logic [DW-1:0]  wb_wdata,
   output logic           stall,
   output logic           flush,
   output logic [1:0]     fwd1,
   output logic [1:0]     fwd2,
   output logic [DW-1:0]  ex_opa,
   output logic [DW-1:0]  ex_opb,
   output logic [CW-1:0]  stall_cnt,
   output logic [CW-1:0]  flush_cnt
);

   localparam logic          R0_Z    = (R0_ZERO != 0);
   localparam logic [CW-1:0] CNT_MAX = '1;

   slot_t     ex_q;
   slot_t     mem_q;
   slot_t     wb_q;
   slot_t     ex_d;
   reg_addr_t id_rs1_x;
   reg_addr_t id_rs2_x;
   logic      ex_hit1;
   logic      ex_hit2;
   logic      load_use;
   logic      mem_hit1;
   logic      mem_hit2;
   logic      wb_hit1;
   logic      wb_hit2;
   logic      wb_fields_unused;

   assign id_rs1_x = reg_addr_t'(id_rs1);
   assign id_rs2_x = reg_addr_t'(id_rs2);

   // A load in EX cannot feed the instruction in ID until it reaches MEM.
   assign ex_hit1  = slot_match(ex_q.valid, ex_q.wen, ex_q.dst, id_rs1_x, id_use1, R0_Z);
   assign ex_hit2  = slot_match(ex_q.valid, ex_q.wen, ex_q.dst, id_rs2_x, id_use2, R0_Z);
   assign load_use = id_valid && ex_q.load && (ex_hit1 || ex_hit2);

   assign flush = ex_taken;
   assign stall = load_use && !ex_taken;

   // Load data is not yet available in MEM, so a MEM load never forwards.
   assign mem_hit1 = slot_match(mem_q.valid, mem_q.wen, mem_q.dst, ex_q.rs1, ex_q.use1, R0_Z)
                     && !mem_q.load;
   assign mem_hit2 = slot_match(mem_q.valid, mem_q.wen, mem_q.dst, ex_q.rs2, ex_q.use2, R0_Z)
                     && !mem_q.load;
   assign wb_hit1  = slot_match(wb_q.valid, wb_q.wen, wb_q.dst, ex_q.rs1, ex_q.use1, R0_Z);
   assign wb_hit2  = slot_match(wb_q.valid, wb_q.wen, wb_q.dst, ex_q.rs2, ex_q.use2, R0_Z);

   always_comb begin
      fwd1 = FWD_REG;
      fwd2 = FWD_REG;
      if (mem_hit1) begin
         fwd1 = FWD_MEM;
      end else if (wb_hit1) begin
         fwd1 = FWD_WB;
      end
      if (mem_hit2) begin
         fwd2 = FWD_MEM;
      end else if (wb_hit2) begin
         fwd2 = FWD_WB;
      end
   end

   always_comb begin
      ex_d = SLOT_BUBBLE;
      if (!(stall || flush)) begin
         ex_d.valid = id_valid;
         ex_d.wen   = id_wen;
         ex_d.dst   = reg_addr_t'(id_wdst);
         ex_d.load  = id_load;
         ex_d.rs1   = id_rs1_x;
         ex_d.rs2   = id_rs2_x;
         ex_d.use1  = id_use1;
         ex_d.use2  = id_use2;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ex_q  <= SLOT_BUBBLE;
         mem_q <= SLOT_BUBBLE;
         wb_q  <= SLOT_BUBBLE;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   // Event counters stick at all-ones rather than wrapping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CW'(1);
         end
         if (flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CW'(1);
         end
      end
   end

   // The WB slot only ever acts as a producer; its source fields ride along unused.
   assign wb_fields_unused = ^{wb_q.rs1, wb_q.rs2, wb_q.use1, wb_q.use2, wb_q.load};

   pmips_fwd_mux #(.DW(DW)) u_mux_a (
      .sel      (fwd1),
      .reg_data (ex_rdata1),
      .mem_data (mem_result),
      .wb_data  (wb_wdata),
      .operand  (ex_opa)
   );

   pmips_fwd_mux #(.DW(DW)) u_mux_b (
      .sel      (fwd2),
      .reg_data (ex_rdata2),
      .mem_data (mem_result),
      .wb_data  (wb_wdata),
      .operand  (ex_opb)
   );

endmodule

// File: doc/pmips_hazard_unit.md
# pmips_hazard_unit

Parametrised hazard-detection and forwarding unit for the pipelined MIPS-lite core (IF/ID/EX/MEM/WB). It tracks the destination registers of in-flight instructions in EX, MEM and WB. It drives the load-use stall, the branch flush and the EX-stage operand forwarding muxes, and it counts stall and flush events for debug. It sits beside the ID/EX pipeline register, and its forwarded operands feed the ALU inputs directly.

## Interface
Parameters:
- DW, 16, datapath width
- RAW, 3, register address width (2**RAW registers)
- CW, 16, width of each event counter
- R0_ZERO, 1, register 0 is hardwired zero: never matched for hazards or forwarding

Ports:
- clock  in  1  sole clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RAW  ID source register fields
- id_use1, id_use2  in  1  ID instruction actually reads rs1/rs2
- id_wen  in  1  ID instruction writes the register file
- id_wdst  in  RAW  ID destination register (after RegDst mux)
- id_load  in  1  ID instruction is a load (MemRead)
- ex_taken  in  1  branch or jump in EX resolved taken
- ex_rdata1, ex_rdata2  in  DW  ID/EX register-file operands
- mem_result  in  DW  EX/MEM ALU result
- wb_wdata  in  DW  WB write-data (after MemtoReg mux)
- stall  out  1  hold PC and IF/ID; ID/EX takes a bubble
- flush  out  1  clear IF/ID and ID/EX (insert nops)
- fwd1, fwd2  out  2  operand select for EX: 0 register, 1 MEM, 2 WB
- ex_opa, ex_opb  out  DW  forwarded operands to the ALU
- stall_cnt, flush_cnt  out  CW  saturating event counters

## Operation
- The unit keeps three slots: EX, MEM and WB. Each slot holds valid, wen, dst and load. The EX slot also holds rs1, rs2, use1 and use2.
- Every posedge: WB<=MEM, MEM<=EX, and EX<=ID fields, with valid=id_valid.
- When stall or flush is asserted, EX<=bubble (valid=0) instead of the ID fields.
- A match means: the slot is valid, the slot's wen is 1, the slot's dst equals the source register, the use bit is set, and the register is not 0 when R0_ZERO=1.
- Load-use: stall=1 when id_valid, the EX slot has load=1, and the EX slot matches id_rs1 or id_rs2.
  - The stall lasts exactly one cycle. On the following cycle the load is in MEM and the ID instruction is re-evaluated. There is no MEM-load stall: WB forwarding covers that case.
- flush=ex_taken. Flush takes priority: if ex_taken and a load-use condition occur in the same cycle, stall=0.
- Forwarding is for the EX slot, selected per operand in priority order:
  - MEM match that is not a load: select 1.
  - Otherwise WB match: select 2.
  - Otherwise: select 0.
  - A MEM slot holding a load never forwards.
- ID needs no WB bypass: the register file writes on the negative clock edge.
- ex_opa/ex_opb = mux(fwd, ex_rdata, mem_result, wb_wdata).
- Counters: stall_cnt increments once per cycle with stall=1; flush_cnt increments once per cycle with flush=1. Both saturate at 2**CW-1 and do not wrap.

## Timing
- stall, flush, fwd1/2 and ex_opa/b are combinational from the slot registers and current inputs. Each is a single level of compare logic, with no extra cycle of latency.
- Slot and counter state change only on posedge clock or asynchronous reset.
- Reset values: all slots invalid, so stall=0, fwd1=fwd2=0, ex_opa=ex_rdata1, ex_opb=ex_rdata2. Counters are 0. flush follows ex_taken.
- Reset asserted mid-stall clears all slots immediately. The first cycle after release has no hazards.
- Back-to-back load-uses produce one stall each, never merged.

## Structure
- The shared package pmips_pkg holds the forward-select constants FWD_REG=0, FWD_MEM=1, FWD_WB=2 and the slot struct (valid, wen, dst, load, rs1, rs2, use1, use2).
- One sub-module, pmips_fwd_mux (parametrised by DW), is instantiated twice: once per operand.

## Test plan
- Load `lw $3` followed by `add $4,$3,$1` → stall=1 for exactly 1 cycle, then fwd1=2 with ex_opa=wb_wdata=0x1234. stall_cnt=1.
- `add $2`, then `sub $5,$2,$2` → no stall. fwd1=fwd2=1, and ex_opa=ex_opb=mem_result=0x00AA.
- `add $2`, `add $2`, then a reader of $2 → MEM wins over WB: fwd1=1.
- Writer of $0, then a reader of $0 with R0_ZERO=1 → no stall, fwd=0.
- ex_taken=1 in the same cycle as a load-use → flush=1, stall=0. The next EX slot is invalid, and flush_cnt=1.
- Force stall for 2**CW+3 cycles with CW=4 → stall_cnt holds at 15. Reset asserted mid-stall → stall drops asynchronously and the counters read 0.
